// File: rtl/pid_step_scheduler_pkg.sv
// ============================================================================
// Module   : pid_step_scheduler_pkg
// Purpose  : Shared defaults for the PID step scheduler slice.
//            Holds the per-step channel count (one channel per wind turbine),
//            the default timing constants and the index-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pid_step_scheduler_pkg;

  // Number of wind turbines sharing one PID pipeline.
  localparam int N_WIND_TURBINE = 32;

  // Default step timing, in clock cycles.
  localparam int DEF_LEAD       = 15;
  localparam int DEF_LAT        = 20;
  localparam int DEF_SLACK      = 8;
  localparam int DEF_INIT_STEPS = 1;

  // Index width for a channel count; never less than one bit.
  function automatic int chan_idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pid_step_scheduler_if.sv
// ============================================================================
// Module   : pid_step_scheduler_if
// Purpose  : Bundles the step handshake between the time-step controller /
//            PID datapath (master side) and the step scheduler (slave side).
// Ports    : master drives step_req, done_sig; slave drives every other signal.
//            step_req/done_sig : 1-cycle request / first-result pulses
//            done_read, sta    : FIFO read lead pulse, datapath start pulse
//            ch_valid/ch_idx   : issue window and channel
//            res_valid/res_idx : result window and channel
//            init_mode, busy, step_done, step_cnt, err_overrun, err_timeout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pid_step_scheduler_if
  import pid_step_scheduler_pkg::*;
#(
  parameter int CW = chan_idx_width(N_WIND_TURBINE)
);
  logic          step_req;
  logic          done_sig;
  logic          done_read;
  logic          sta;
  logic          ch_valid;
  logic [CW-1:0] ch_idx;
  logic          res_valid;
  logic [CW-1:0] res_idx;
  logic          init_mode;
  logic          busy;
  logic          step_done;
  logic [15:0]   step_cnt;
  logic          err_overrun;
  logic          err_timeout;

  modport master (
    output step_req, done_sig,
    input  done_read, sta, ch_valid, ch_idx, res_valid, res_idx,
           init_mode, busy, step_done, step_cnt, err_overrun, err_timeout
  );

  modport slave (
    input  step_req, done_sig,
    output done_read, sta, ch_valid, ch_idx, res_valid, res_idx,
           init_mode, busy, step_done, step_cnt, err_overrun, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/pid_chan_counter.sv
// ============================================================================
// Module   : pid_chan_counter
// Purpose  : Modulo-N_CH channel walker. A start pulse opens a window of
//            N_CH cycles with idx running 0..N_CH-1; clr aborts it at once.
// Ports    : clk, rst (async, active-low), clr (sync abort), start
//            active : window open (registered)
//            idx    : current channel (registered, 0 when idle)
//            last   : active and idx == N_CH-1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_chan_counter
  import pid_step_scheduler_pkg::*;
#(
  parameter int N_CH = N_WIND_TURBINE,
  parameter int CW   = chan_idx_width(N_WIND_TURBINE)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr,
  input  wire logic          start,
  output logic               active,
  output logic [CW-1:0]      idx,
  output logic               last
);

  localparam logic [CW-1:0] c_idx_last = CW'(N_CH - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      idx    <= '0;
    end else if (clr) begin
      active <= 1'b0;
      idx    <= '0;
    end else if (start) begin
      active <= 1'b1;
      idx    <= '0;
    end else if (active) begin
      if (idx == c_idx_last) begin
        active <= 1'b0;
        idx    <= '0;
      end else begin
        idx <= idx + CW'(1);
      end
    end
  end

  assign last = active && (idx == c_idx_last);

endmodule

`default_nettype wire

// File: rtl/pid_step_scheduler.sv
// ============================================================================
// Module   : pid_step_scheduler
// Purpose  : Sequences one time step of the time-multiplexed PID datapath:
//            done_read lead pulse, sta LEAD cycles later, issue window of
//            N_CH channels, result window after the first done_sig, then a
//            one-cycle step_done. Tracks init mode, overrun and timeout.
// Ports    : clk      - system clock
//            rst      - asynchronous reset, active-low
//            rst_user - synchronous soft clear with the same effect as rst
//            bus      - slave side of pid_step_scheduler_if
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_step_scheduler
  import pid_step_scheduler_pkg::*;
#(
  parameter int N_CH       = N_WIND_TURBINE,
  parameter int CW         = chan_idx_width(N_WIND_TURBINE),
  parameter int LEAD       = DEF_LEAD,
  parameter int LAT        = DEF_LAT,
  parameter int SLACK      = DEF_SLACK,
  parameter int INIT_STEPS = DEF_INIT_STEPS
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              rst_user,
  pid_step_scheduler_if.slave    bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_prep = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = c_st_idle,
    ST_PREP = c_st_prep,
    ST_RUN  = c_st_run,
    ST_DONE = c_st_done
  } state_e;

  // Counters compare against "last value" so the event lands on the exact
  // edge: LEAD edges after done_read for sta, LAT+SLACK after sta for timeout.
  localparam logic [15:0] c_lead_last   = 16'(LEAD - 1);
  localparam logic [15:0] c_to_last     = 16'(LAT + SLACK - 1);
  localparam logic [15:0] c_init_steps  = 16'(INIT_STEPS);
  localparam logic        c_init_reset  = (INIT_STEPS != 0);

  state_e        r_state;
  logic          r_busy;
  logic          r_done_read;
  logic          r_sta;
  logic          r_step_done;
  logic [15:0]   r_step_cnt;
  logic          r_err_overrun;
  logic          r_err_timeout;
  logic          r_init_mode;
  logic [15:0]   r_init_left;
  logic [15:0]   r_lead_cnt;
  logic [15:0]   r_to_cnt;
  logic          r_got_done;
  logic          r_aborted;
  logic          r_issue_done;
  logic          r_res_done;

  logic          w_issue_start;
  logic          w_issue_active;
  logic [CW-1:0] w_issue_idx;
  logic          w_issue_last;
  logic          w_res_start;
  logic          w_res_active;
  logic [CW-1:0] w_res_idx;
  logic          w_res_last;
  logic          w_timeout;
  logic          w_all_done;
  logic          w_win_clr;

  assign w_issue_start = (r_state == ST_PREP) && (r_lead_cnt == c_lead_last);
  // Only the first done_sig of a RUN opens the result window.
  assign w_res_start   = (r_state == ST_RUN) && bus.done_sig && !r_got_done && !r_aborted;
  // A done_sig on the final allowed edge still counts as on time.
  assign w_timeout     = (r_state == ST_RUN) && !r_got_done && !r_aborted &&
                         !bus.done_sig && (r_to_cnt == c_to_last);
  assign w_all_done    = (r_issue_done || w_issue_last) && (r_res_done || w_res_last);
  // Timeout tears both windows down on the same edge it is detected.
  assign w_win_clr     = rst_user || w_timeout;

  pid_chan_counter #(.N_CH(N_CH), .CW(CW)) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_win_clr),
    .start  (w_issue_start),
    .active (w_issue_active),
    .idx    (w_issue_idx),
    .last   (w_issue_last)
  );

  pid_chan_counter #(.N_CH(N_CH), .CW(CW)) u_res_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_win_clr),
    .start  (w_res_start),
    .active (w_res_active),
    .idx    (w_res_idx),
    .last   (w_res_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done_read   <= 1'b0;
      r_sta         <= 1'b0;
      r_step_done   <= 1'b0;
      r_step_cnt    <= '0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
      r_init_mode   <= c_init_reset;
      r_init_left   <= c_init_steps;
      r_lead_cnt    <= '0;
      r_to_cnt      <= '0;
      r_got_done    <= 1'b0;
      r_aborted     <= 1'b0;
      r_issue_done  <= 1'b0;
      r_res_done    <= 1'b0;
    end else if (rst_user) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done_read   <= 1'b0;
      r_sta         <= 1'b0;
      r_step_done   <= 1'b0;
      r_step_cnt    <= '0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
      r_init_mode   <= c_init_reset;
      r_init_left   <= c_init_steps;
      r_lead_cnt    <= '0;
      r_to_cnt      <= '0;
      r_got_done    <= 1'b0;
      r_aborted     <= 1'b0;
      r_issue_done  <= 1'b0;
      r_res_done    <= 1'b0;
    end else begin
      r_done_read <= 1'b0;
      r_sta       <= 1'b0;
      r_step_done <= 1'b0;

      // Any request outside IDLE (DONE included) is dropped, not queued.
      if (bus.step_req && (r_state != ST_IDLE)) r_err_overrun <= 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          if (bus.step_req) begin
            r_done_read <= 1'b1;
            r_lead_cnt  <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_PREP;
          end
        end

        ST_PREP: begin
          if (w_issue_start) begin
            r_sta        <= 1'b1;
            r_to_cnt     <= '0;
            r_got_done   <= 1'b0;
            r_aborted    <= 1'b0;
            r_issue_done <= 1'b0;
            r_res_done   <= 1'b0;
            r_state      <= ST_RUN;
          end else begin
            r_lead_cnt <= r_lead_cnt + 16'd1;
          end
        end

        ST_RUN: begin
          // After a timeout the windows are already closed; leave one cycle
          // later so err_timeout is visible before step_done.
          if (r_aborted || w_all_done) begin
            r_step_done <= 1'b1;
            r_step_cnt  <= r_step_cnt + 16'd1;
            r_state     <= ST_DONE;
          end else begin
            if (w_issue_last) r_issue_done <= 1'b1;
            if (w_res_last)   r_res_done   <= 1'b1;
            if (w_res_start) begin
              r_got_done <= 1'b1;
            end else if (w_timeout) begin
              r_aborted     <= 1'b1;
              r_err_timeout <= 1'b1;
            end else if (!r_got_done) begin
              r_to_cnt <= r_to_cnt + 16'd1;
            end
          end
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          // init_mode flips only here so it is stable across a whole step.
          if (r_init_left != 16'd0) begin
            r_init_left <= r_init_left - 16'd1;
            r_init_mode <= (r_init_left > 16'd1);
          end
        end
      endcase
    end
  end

  assign bus.done_read   = r_done_read;
  assign bus.sta         = r_sta;
  assign bus.ch_valid    = w_issue_active;
  assign bus.ch_idx      = w_issue_idx;
  assign bus.res_valid   = w_res_active;
  assign bus.res_idx     = w_res_idx;
  assign bus.init_mode   = r_init_mode;
  assign bus.busy        = r_busy;
  assign bus.step_done   = r_step_done;
  assign bus.step_cnt    = r_step_cnt;
  assign bus.err_overrun = r_err_overrun;
  assign bus.err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pid_step_scheduler.sv
// ============================================================================
// Module   : tb_pid_step_scheduler
// Purpose  : Directed self-checking bench for pid_step_scheduler with
//            N_CH=32, LEAD=15, LAT=20, SLACK=8, INIT_STEPS=1.
//            Cycle c is the clock period ending at rising edge c; inputs for
//            cycle c are driven just after edge c-1, outputs sampled on the
//            falling edge inside cycle c.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_step_scheduler;

  logic clk;
  logic rst;
  logic rst_user;
  int   checks;
  int   failures;

  // Output snapshot layout (35 bits):
  // {done_read, sta, ch_valid, ch_idx[4:0], res_valid, res_idx[4:0],
  //  init_mode, busy, step_done, step_cnt[15:0], err_overrun, err_timeout}
  localparam int STA_BIT = 33;
  logic [34:0] obs [0:255];

  pid_step_scheduler_if #(.CW(5)) bus ();

  pid_step_scheduler #(
    .N_CH(32), .CW(5), .LEAD(15), .LAT(20), .SLACK(8), .INIT_STEPS(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rst_user (rst_user),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] snap();
    return {bus.done_read, bus.sta, bus.ch_valid, bus.ch_idx, bus.res_valid,
            bus.res_idx, bus.init_mode, bus.busy, bus.step_done, bus.step_cnt,
            bus.err_overrun, bus.err_timeout};
  endfunction

  function automatic logic [34:0] mk(input bit dr, input bit st, input bit cv,
                                     input logic [4:0] ci, input bit rv,
                                     input logic [4:0] ri, input bit im,
                                     input bit bz, input bit sd,
                                     input logic [15:0] cnt, input bit ov,
                                     input bit to);
    return {dr, st, cv, ci, rv, ri, im, bz, sd, cnt, ov, to};
  endfunction

  // Expected outputs in cycle c for a nominal step requested in cycle k:
  // done_read k+1, sta k+16, issue k+16..k+47, results k+37..k+68,
  // step_done k+69. init_mode switches from init0 to init1 after step_done.
  function automatic logic [34:0] nominal(input int c, input int k,
                                          input int cnt0, input bit init0,
                                          input bit init1);
    bit cv;
    bit rv;
    cv = (c >= k + 16) && (c <= k + 47);
    rv = (c >= k + 37) && (c <= k + 68);
    return mk(c == k + 1, c == k + 16, cv, cv ? 5'(c - k - 16) : 5'd0,
              rv, rv ? 5'(c - k - 37) : 5'd0,
              (c <= k + 69) ? init0 : init1,
              (c >= k + 1) && (c <= k + 69), c == k + 69,
              16'(cnt0 + ((c >= k + 69) ? 1 : 0)), 1'b0, 1'b0);
  endfunction

  task automatic do_reset();
    rst          = 1'b0;
    rst_user     = 1'b0;
    bus.step_req = 1'b0;
    bus.done_sig = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs cycles 1..n. model=1 returns done_sig 20 cycles after each sta seen.
  task automatic run(input int n, input int r0, input int r1, input int r2,
                     input bit model, input int spur, input int rst_at,
                     input int rstu_at);
    for (int c = 1; c <= n; c++) begin
      bus.step_req = (c == r0) || (c == r1) || (c == r2);
      bus.done_sig = (model && (c > 20) && obs[c - 20][STA_BIT]) || (c == spur);
      rst          = (c == rst_at) ? 1'b0 : 1'b1;
      rst_user     = (c == rstu_at);
      @(negedge clk);
      obs[c] = snap();
      @(posedge clk);
      #1;
    end
    bus.step_req = 1'b0;
    bus.done_sig = 1'b0;
    rst          = 1'b1;
    rst_user     = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] e;
    logic [34:0] got;
    rst = 1'b0; rst_user = 1'b0; bus.step_req = 1'b0; bus.done_sig = 1'b0;
    @(negedge clk);
    got = snap();
    e = mk(0, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 16'd0, 0, 0);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got, e);
    end
    do_reset();
    run(6, 0, 0, 0, 1'b0, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (obs[c] !== e) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs[c], e);
      end
    end
  endtask

  // Two back-to-back nominal steps; a second done_sig in step one is ignored.
  task automatic test_nominal();
    logic [34:0] e;
    do_reset();
    run(170, 10, 90, 0, 1'b1, 60, 0, 0);
    for (int c = 1; c <= 170; c++) begin
      e = (c < 85) ? nominal(c, 10, 0, 1'b1, 1'b0) : nominal(c, 90, 1, 1'b0, 1'b0);
      checks++;
      if (obs[c] !== e) begin
        failures++;
        $display("FAIL nominal cyc=%0d got=%h exp=%h", c, obs[c], e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [34:0] e;
    do_reset();
    run(90, 10, 40, 0, 1'b1, 0, 0, 0);
    for (int c = 1; c <= 90; c++) begin
      e = nominal(c, 10, 0, 1'b1, 1'b0);
      e[1] = (c >= 41);
      checks++;
      if (obs[c] !== e) begin
        failures++;
        $display("FAIL overrun cyc=%0d got=%h exp=%h", c, obs[c], e);
      end
    end
  endtask

  // Request during the DONE cycle is dropped; the next one in IDLE runs.
  task automatic test_back_to_back();
    logic [34:0] e;
    do_reset();
    run(160, 10, 79, 85, 1'b1, 0, 0, 0);
    for (int c = 1; c <= 160; c++) begin
      e = (c < 85) ? nominal(c, 10, 0, 1'b1, 1'b0) : nominal(c, 85, 1, 1'b0, 1'b0);
      e[1] = (c >= 80);
      checks++;
      if (obs[c] !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs[c], e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [34:0] e;
    bit cv;
    do_reset();
    run(70, 10, 0, 0, 1'b0, 0, 0, 0);
    for (int c = 1; c <= 70; c++) begin
      cv = (c >= 26) && (c <= 53);
      e = mk(c == 11, c == 26, cv, cv ? 5'(c - 26) : 5'd0, 1'b0, 5'd0,
             c <= 55, (c >= 11) && (c <= 55), c == 55,
             (c >= 55) ? 16'd1 : 16'd0, 1'b0, c >= 54);
      checks++;
      if (obs[c] !== e) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs[c], e);
      end
    end
  endtask

  // rst low in cycle 35; the orphaned done_sig in cycle 46 lands in IDLE.
  task automatic test_reset_abort();
    logic [34:0] e;
    do_reset();
    run(140, 10, 60, 0, 1'b1, 0, 35, 0);
    for (int c = 1; c <= 140; c++) begin
      e = (c < 35) ? nominal(c, 10, 0, 1'b1, 1'b0) : nominal(c, 60, 0, 1'b1, 1'b0);
      checks++;
      if (obs[c] !== e) begin
        failures++;
        $display("FAIL reset_abort cyc=%0d got=%h exp=%h", c, obs[c], e);
      end
    end
  endtask

  // rst_user sampled at edge 35 clears from cycle 36; done_sig in IDLE at 5.
  task automatic test_soft_reset();
    logic [34:0] e;
    do_reset();
    run(140, 10, 60, 0, 1'b1, 5, 0, 35);
    for (int c = 1; c <= 140; c++) begin
      e = (c <= 35) ? nominal(c, 10, 0, 1'b1, 1'b0) : nominal(c, 60, 0, 1'b1, 1'b0);
      checks++;
      if (obs[c] !== e) begin
        failures++;
        $display("FAIL soft_reset cyc=%0d got=%h exp=%h", c, obs[c], e);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    rst_user     = 1'b0;
    bus.step_req = 1'b0;
    bus.done_sig = 1'b0;
    for (int i = 0; i < 256; i++) obs[i] = '0;
    test_reset();
    test_nominal();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_reset_abort();
    test_soft_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
